conv_ctrl_12_5: RTL



---
 rtl/conv_ctrl_12_5_if.sv | 32 +++
 rtl/conv_ctrl_12_5.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/conv_ctrl_12_5_if.sv
// Handshake and memory-control bundle between the convolution controller and its datapath.
interface conv_ctrl_12_5_if #(
  parameter int XAW = 4,
  parameter int FAW = 3
);
  logic           x_valid;
  logic           x_ready;
  logic           f_valid;
  logic           f_ready;
  logic           y_valid;
  logic           y_ready;
  logic [XAW-1:0] x_addr;
  logic           x_wr_en;
  logic [FAW-1:0] f_addr;
  logic           f_wr_en;
  logic           acc_clr;
  logic           acc_en;

  modport master (
    input  x_valid, f_valid, y_ready,
    output x_ready, f_ready, y_valid,
    output x_addr, x_wr_en, f_addr, f_wr_en,
    output acc_clr, acc_en
  );

  modport slave (
    output x_valid, f_valid, y_ready,
    input  x_ready, f_ready, y_valid,
    input  x_addr, x_wr_en, f_addr, f_wr_en,
    input  acc_clr, acc_en
  );
endinterface

// File: rtl/conv_ctrl_12_5.sv
// Sequencing FSM for a 1-D convolution datapath: loads x and f, then steps the
// multiply-accumulate through M taps per output and hands each result out.
module conv_ctrl_12_5 #(
  parameter int N   = 12,
  parameter int M   = 5,
  parameter int XAW = 4,
  parameter int FAW = 3
) (
  input  logic             clk,
  input  logic             reset,
  conv_ctrl_12_5_if.master bus
);
  localparam int NOUT = N - M + 1;
  localparam int XCW  = $clog2(N + 1);
  localparam int FCW  = $clog2(M + 1);
  localparam int OW   = $clog2(NOUT + 1);
  localparam int KW   = $clog2(M + 1);

  localparam logic [XCW-1:0] X_FULL = XCW'(N);
  localparam logic [FCW-1:0] F_FULL = FCW'(M);
  localparam logic [OW-1:0]  O_DONE = OW'(NOUT);
  localparam logic [KW-1:0]  K_LAST = KW'(M - 1);

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    DRAIN,
    OUTPUT
  } state_t;

  state_t         state, state_nxt;
  logic [XCW-1:0] x_cnt, x_cnt_nxt;
  logic [FCW-1:0] f_cnt, f_cnt_nxt;
  logic [OW-1:0]  out_idx, out_idx_nxt;
  logic [KW-1:0]  k, k_nxt;

  logic           x_ready;
  logic           f_ready;
  logic           x_wr;
  logic           f_wr;
  logic           y_vld;
  logic [XAW-1:0] x_addr_c;
  logic [FAW-1:0] f_addr_c;

  logic           vld_p0;
  logic           clr_p0;
  logic           vld_p1;
  logic           clr_p1;

  // Once a stream is full its counter sits at the length; park the address at 0
  // so it never points past the memory.
  function automatic logic [XAW-1:0] x_load_addr(input logic [XCW-1:0] cnt);
    return (cnt < X_FULL) ? XAW'(cnt) : '0;
  endfunction

  function automatic logic [FAW-1:0] f_load_addr(input logic [FCW-1:0] cnt);
    return (cnt < F_FULL) ? FAW'(cnt) : '0;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= LOAD;
      x_cnt   <= '0;
      f_cnt   <= '0;
      out_idx <= '0;
      k       <= '0;
      vld_p1  <= 1'b0;
      clr_p1  <= 1'b0;
    end else begin
      state   <= state_nxt;
      x_cnt   <= x_cnt_nxt;
      f_cnt   <= f_cnt_nxt;
      out_idx <= out_idx_nxt;
      k       <= k_nxt;
      vld_p1  <= vld_p0;
      clr_p1  <= clr_p0;
    end
  end

  always_comb begin
    state_nxt   = state;
    x_cnt_nxt   = x_cnt;
    f_cnt_nxt   = f_cnt;
    out_idx_nxt = out_idx;
    k_nxt       = k;
    x_ready     = 1'b0;
    f_ready     = 1'b0;
    x_wr        = 1'b0;
    f_wr        = 1'b0;
    y_vld       = 1'b0;
    vld_p0      = 1'b0;
    clr_p0      = 1'b0;
    x_addr_c    = '0;
    f_addr_c    = '0;

    case (state)
      LOAD: begin
        x_ready  = (x_cnt < X_FULL);
        f_ready  = (f_cnt < F_FULL);
        x_wr     = bus.x_valid & x_ready;
        f_wr     = bus.f_valid & f_ready;
        x_addr_c = x_load_addr(x_cnt);
        f_addr_c = f_load_addr(f_cnt);
        if (x_wr) x_cnt_nxt = x_cnt + 1'b1;
        if (f_wr) f_cnt_nxt = f_cnt + 1'b1;
        // Start computing on the same edge that lands the last outstanding word.
        if ((x_cnt_nxt == X_FULL) && (f_cnt_nxt == F_FULL)) begin
          state_nxt = COMPUTE;
          k_nxt     = '0;
        end
      end

      COMPUTE: begin
        vld_p0   = 1'b1;
        clr_p0   = (k == '0);
        x_addr_c = XAW'(out_idx) + XAW'(k);
        f_addr_c = FAW'(k);
        if (k == K_LAST) begin
          state_nxt = DRAIN;
          k_nxt     = '0;
        end else begin
          k_nxt = k + 1'b1;
        end
      end

      DRAIN: begin
        x_addr_c  = XAW'(out_idx);
        state_nxt = OUTPUT;
      end

      OUTPUT: begin
        y_vld    = 1'b1;
        x_addr_c = XAW'(out_idx);
        if (bus.y_ready) begin
          if ((out_idx + 1'b1) == O_DONE) begin
            state_nxt   = LOAD;
            x_cnt_nxt   = '0;
            f_cnt_nxt   = '0;
            out_idx_nxt = '0;
          end else begin
            state_nxt   = COMPUTE;
            out_idx_nxt = out_idx + 1'b1;
          end
        end
      end

      default: state_nxt = LOAD;
    endcase
  end

  // Stage p0 -> p1: read strobe delayed to line up with the registered memory output.
  assign bus.acc_en  = vld_p1;
  assign bus.acc_clr = clr_p1;

  assign bus.x_ready = x_ready;
  assign bus.f_ready = f_ready;
  assign bus.x_wr_en = x_wr;
  assign bus.f_wr_en = f_wr;
  assign bus.y_valid = y_vld;
  assign bus.x_addr  = x_addr_c;
  assign bus.f_addr  = f_addr_c;
endmodule
